// File: rtl/iserdes_period_sequencer.sv
// Period-measurement sequencer for the ISERDES change detector: arms on START,
// timestamps the first transition, counts N more and reports the duration in 1/8-cycle units.
module iserdes_period_sequencer #(
    parameter int unsigned TS_BITS        = 24,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               CHANGED_FLAG,
    input  logic [2:0]         CHANGED_BIT,
    input  logic               START,
    input  logic [7:0]         EDGES,
    output logic               BUSY,
    output logic [TS_BITS-1:0] RESULT,
    output logic [7:0]         RESULT_EDGES,
    output logic               TIMEOUT,
    output logic               RESULT_VALID,
    input  logic               RESULT_READY
);

    localparam int unsigned CNT_W = TS_BITS - 3;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [7:0]         n_q, n_d;
    logic [7:0]         rem_q, rem_d;
    logic [TS_BITS-1:0] t0_q, t0_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [TS_BITS-1:0] result_q, result_d;
    logic [7:0]         res_edges_q, res_edges_d;
    logic               timeout_q, timeout_d;

    logic [TS_BITS-1:0] ts;
    logic               to_expired;

    // Fine timestamp: coarse cycle count with the detector's sub-cycle position appended.
    assign ts         = {cyc_q, CHANGED_BIT};
    assign to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            n_q         <= '0;
            rem_q       <= '0;
            t0_q        <= '0;
            to_q        <= '0;
            result_q    <= '0;
            res_edges_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            n_q         <= n_d;
            rem_q       <= rem_d;
            t0_q        <= t0_d;
            to_q        <= to_d;
            result_q    <= result_d;
            res_edges_q <= res_edges_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q + 1'b1;
        n_d         = n_q;
        rem_d       = rem_q;
        t0_d        = t0_q;
        to_d        = to_q;
        result_d    = result_q;
        res_edges_d = res_edges_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    n_d     = (EDGES == 8'd0) ? 8'd1 : EDGES;
                    to_d    = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (CHANGED_FLAG) begin
                    t0_d    = ts;
                    rem_d   = n_q;
                    to_d    = '0;
                    state_d = S_MEASURE;
                end else if (to_expired) begin
                    result_d    = '0;
                    res_edges_d = '0;
                    timeout_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // An edge in the expiry cycle takes priority over the timeout.
                if (CHANGED_FLAG) begin
                    rem_d = rem_q - 1'b1;
                    to_d  = '0;
                    if (rem_q == 8'd1) begin
                        result_d    = ts - t0_q;
                        res_edges_d = n_q;
                        timeout_d   = 1'b0;
                        state_d     = S_DONE;
                    end
                end else if (to_expired) begin
                    result_d    = '0;
                    res_edges_d = n_q - rem_q;
                    timeout_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DONE: begin
                if (RESULT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY         = (state_q == S_ARM) || (state_q == S_MEASURE);
    assign RESULT_VALID = (state_q == S_DONE);
    assign RESULT       = result_q;
    assign RESULT_EDGES = res_edges_q;
    assign TIMEOUT      = timeout_q;

endmodule
